// File: rtl/uart_pkg.sv
// Shared UART definitions: parser states, error codes, the default sync marker
// and the bit-period helper used by both the receiver and the command controller.
package uart_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } parse_state_e;

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_OVR = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: reloads on every byte and counts down while a frame is open.
// expired_o fires for one cycle on the edge where TIMEOUT_CLKS-1 idle cycles have elapsed.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 41640
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CLKS);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the idle cycles still remaining; a clear reloads the full window.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = W'(TIMEOUT_CLKS - 1);
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the expiry cycle wins, so clear masks the pulse.
  assign expired_o = enable_i && !clear_i && (cnt_q == W'(1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser (SYNC, ADDR, DATA, CHK) feeding a one-deep command register with
// valid/ready handshake, plus checksum/timeout/overrun error reporting.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         CLK_HZ        = 10_000_000,
  parameter int         BAUD_RATE     = 9600,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic       source_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic       o_cmd_rw,
  output logic [6:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_err_count
);

  localparam int TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * clks_per_bit(CLK_HZ, BAUD_RATE);

  parse_state_e state_q, state_d;
  logic [7:0]   addr_byte_q, addr_byte_d;
  logic [7:0]   data_byte_q, data_byte_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic         cmd_rw_q, cmd_rw_d;
  logic [6:0]   cmd_addr_q, cmd_addr_d;
  logic [7:0]   cmd_data_q, cmd_data_d;
  logic         err_q, err_d;
  logic [1:0]   err_code_q, err_code_d;
  logic [7:0]   err_count_q, err_count_d;
  logic         chk_ok;
  logic         tmo_expired;

  uart_cmd_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk_i    (source_clk),
    .rst_ni   (i_rst_n),
    .clear_i  (i_rx_valid),
    .enable_i (state_q != S_SYNC),
    .expired_o(tmo_expired)
  );

  assign chk_ok = (i_rx_byte == (SYNC_BYTE ^ addr_byte_q ^ data_byte_q));

  // Parser, command register and error bookkeeping share one next-state process
  // because a completing frame decides between load, overrun and checksum error.
  always_comb begin
    state_d     = state_q;
    addr_byte_d = addr_byte_q;
    data_byte_d = data_byte_q;
    cmd_valid_d = cmd_valid_q && !i_cmd_ready;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;

    if (i_rx_valid) begin
      case (state_q)
        S_SYNC: begin
          if (i_rx_byte == SYNC_BYTE) state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_byte_d = i_rx_byte;
          state_d     = S_DATA;
        end
        S_DATA: begin
          data_byte_d = i_rx_byte;
          state_d     = S_CHK;
        end
        S_CHK: begin
          state_d = S_SYNC;
          if (!chk_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end else if (cmd_valid_q && !i_cmd_ready) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVR;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_rw_d    = addr_byte_q[7];
            cmd_addr_d  = addr_byte_q[6:0];
            cmd_data_d  = data_byte_q;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end else if (tmo_expired) begin
      state_d    = S_SYNC;
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
    end

    if (err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge source_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_SYNC;
      addr_byte_q <= '0;
      data_byte_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_byte_q <= addr_byte_d;
      data_byte_q <= data_byte_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_rw    = cmd_rw_q;
  assign o_cmd_addr  = cmd_addr_q;
  assign o_cmd_data  = cmd_data_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_err_count = err_count_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: a frame-level model checked against the DUT every cycle,
// plus directed frames with literal expectations on delivered commands and error counts.
module tb_uart_cmd_ctrl;

  localparam int CLK_HZ       = 96_000;
  localparam int BAUD         = 9600;
  localparam int TMO_BYTES    = 4;
  localparam int TIMEOUT_CLKS = TMO_BYTES * 10 * (CLK_HZ / BAUD);

  logic       clock    = 1'b0;
  logic       rstN     = 1'b0;
  logic       rxValid  = 1'b0;
  logic [7:0] rxByte   = 8'h00;
  logic       cmdReady = 1'b0;
  logic       cmdValid, cmdRw, err;
  logic [6:0] cmdAddr;
  logic [7:0] cmdData, errCount;
  logic [1:0] errCode;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  uart_cmd_ctrl #(
    .CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .TIMEOUT_BYTES(TMO_BYTES), .SYNC_BYTE(8'hA5)
  ) dut (
    .source_clk(clock), .i_rst_n(rstN), .i_rx_valid(rxValid), .i_rx_byte(rxByte),
    .o_cmd_valid(cmdValid), .i_cmd_ready(cmdReady), .o_cmd_rw(cmdRw),
    .o_cmd_addr(cmdAddr), .o_cmd_data(cmdData), .o_err(err),
    .o_err_code(errCode), .o_err_count(errCount)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Frame-level model: collected bytes in a queue, idle cycle count, one pending command.
  logic [7:0] mFrame[$];
  int         mIdle;
  logic       mValid, mRw, mErr;
  logic [6:0] mAddr;
  logic [7:0] mData;
  logic [1:0] mCode;
  int         mCount;

  always @(posedge clock or negedge rstN) begin
    logic       wasPending, loaded;
    logic [1:0] evt;
    if (!rstN) begin
      mFrame.delete();
      mIdle = 0; mValid = 0; mRw = 0; mAddr = 0; mData = 0;
      mErr = 0; mCode = 0; mCount = 0;
    end else begin
      wasPending = mValid;
      loaded     = 1'b0;
      evt        = 2'b00;
      if (rxValid) begin
        mIdle = 0;
        if (mFrame.size() == 0) begin
          if (rxByte == 8'hA5) mFrame.push_back(rxByte);
        end else begin
          mFrame.push_back(rxByte);
          if (mFrame.size() == 4) begin
            if ((mFrame[0] ^ mFrame[1] ^ mFrame[2]) != mFrame[3]) evt = 2'b01;
            else if (wasPending && !cmdReady) evt = 2'b11;
            else begin
              loaded = 1'b1;
              mRw    = mFrame[1][7];
              mAddr  = mFrame[1][6:0];
              mData  = mFrame[2];
            end
            mFrame.delete();
          end
        end
      end else if (mFrame.size() != 0) begin
        mIdle++;
        if (mIdle == TIMEOUT_CLKS - 1) begin
          evt = 2'b10;
          mFrame.delete();
        end
      end
      if (loaded) mValid = 1'b1;
      else if (wasPending && cmdReady) mValid = 1'b0;
      mErr = (evt != 2'b00);
      if (mErr) begin
        mCode = evt;
        if (mCount < 255) mCount++;
      end
    end
  end

  // Per-cycle compare plus a log of DUT transfers and event timestamps.
  logic [15:0] dutLog[$];
  int negCount    = 0;
  int lastValidNeg = -1;
  int lastErrNeg   = -1;

  always @(negedge clock) begin
    checkOutput("cmd_valid", 16'(cmdValid), 16'(mValid));
    checkOutput("err", 16'(err), 16'(mErr));
    checkOutput("err_code", 16'(errCode), 16'(mCode));
    checkOutput("err_count", 16'(errCount), 16'(mCount));
    if (mValid) begin
      checkOutput("cmd_rw", 16'(cmdRw), 16'(mRw));
      checkOutput("cmd_addr", 16'(cmdAddr), 16'(mAddr));
      checkOutput("cmd_data", 16'(cmdData), 16'(mData));
    end
    if (cmdValid && cmdReady) dutLog.push_back({cmdRw, cmdAddr, cmdData});
    if (rxValid) lastValidNeg = negCount;
    if (err) lastErrNeg = negCount;
    negCount++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clock); #2;
    rxValid = 1'b1;
    rxByte  = b;
    @(posedge clock); #2;
    rxValid = 1'b0;
    idle(2);
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    applyStimulus(b0);
    applyStimulus(b1);
    applyStimulus(b2);
    applyStimulus(b3);
  endtask

  initial begin
    idle(3); #2;
    checkOutput("reset_cmd_valid", 16'(cmdValid), 16'h0);
    checkOutput("reset_err_code", 16'(errCode), 16'h0);
    checkOutput("reset_err_count", 16'(errCount), 16'h0);
    rstN     = 1'b1;
    cmdReady = 1'b1;

    sendFrame(8'hA5, 8'h12, 8'h3C, 8'h8B);
    idle(3);
    checkOutput("write_count", 16'(dutLog.size()), 16'd1);
    checkOutput("write_cmd", dutLog[0], 16'h123C);

    sendFrame(8'hA5, 8'h85, 8'h00, 8'h20);
    idle(3);
    checkOutput("read_count", 16'(dutLog.size()), 16'd2);
    checkOutput("read_cmd", dutLog[1], 16'h8500);

    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    sendFrame(8'hA5, 8'h12, 8'h3C, 8'h8B);
    idle(3);
    checkOutput("noise_count", 16'(dutLog.size()), 16'd3);
    checkOutput("noise_cmd", dutLog[2], 16'h123C);
    checkOutput("noise_err_count", 16'(errCount), 16'd0);

    sendFrame(8'hA5, 8'h12, 8'h3C, 8'h00);
    idle(3);
    checkOutput("badchk_count", 16'(dutLog.size()), 16'd3);
    checkOutput("badchk_code", 16'(errCode), 16'h1);
    checkOutput("badchk_err_count", 16'(errCount), 16'd1);
    checkOutput("model_err_count", 16'(mCount), 16'd1);

    applyStimulus(8'hA5);
    applyStimulus(8'h12);
    idle(TIMEOUT_CLKS + 10);
    checkOutput("tmo_latency", 16'(lastErrNeg - lastValidNeg), 16'(TIMEOUT_CLKS));
    checkOutput("tmo_code", 16'(errCode), 16'h2);
    checkOutput("tmo_err_count", 16'(errCount), 16'd2);

    sendFrame(8'hA5, 8'h12, 8'h3C, 8'h8B);
    idle(3);
    checkOutput("after_tmo_count", 16'(dutLog.size()), 16'd4);
    checkOutput("after_tmo_cmd", dutLog[3], 16'h123C);

    @(posedge clock); #2;
    cmdReady = 1'b0;
    sendFrame(8'hA5, 8'h12, 8'h3C, 8'h8B);
    sendFrame(8'hA5, 8'h34, 8'h56, 8'hC7);
    idle(3);
    checkOutput("ovr_held_valid", 16'(cmdValid), 16'h1);
    checkOutput("ovr_held_addr", 16'(cmdAddr), 16'h12);
    checkOutput("ovr_held_data", 16'(cmdData), 16'h3C);
    checkOutput("ovr_code", 16'(errCode), 16'h3);
    checkOutput("ovr_err_count", 16'(errCount), 16'd3);
    @(posedge clock); #2;
    cmdReady = 1'b1;
    idle(3);
    checkOutput("ovr_deliver_count", 16'(dutLog.size()), 16'd5);
    checkOutput("ovr_deliver_cmd", dutLog[4], 16'h123C);
    checkOutput("ovr_valid_fall", 16'(cmdValid), 16'h0);

    @(posedge clock); #2;
    cmdReady = 1'b0;
    sendFrame(8'hA5, 8'h85, 8'h00, 8'h20);
    applyStimulus(8'hA5);
    applyStimulus(8'h12);
    checkOutput("pre_reset_pending", 16'(cmdValid), 16'h1);
    @(posedge clock); #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_rst_valid", 16'(cmdValid), 16'h0);
    checkOutput("async_rst_fields", {1'b0, cmdRw, cmdAddr, cmdData}, 16'h0);
    checkOutput("async_rst_err", 16'({err, errCode}), 16'h0);
    checkOutput("async_rst_err_count", 16'(errCount), 16'h0);
    idle(2); #2;
    rstN     = 1'b1;
    cmdReady = 1'b1;

    sendFrame(8'hA5, 8'h12, 8'h3C, 8'h8B);
    idle(3);
    checkOutput("post_rst_count", 16'(dutLog.size()), 16'd6);
    checkOutput("post_rst_cmd", dutLog[5], 16'h123C);
    checkOutput("post_rst_err_count", 16'(errCount), 16'd0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
